// File: rtl/uart_cmd_parser.sv
// Byte-level UART command parser: decodes 'W'/'R' frames into register-bus transactions.
// Read frames are compiled in only when UART_PARSER_READ_EN is defined.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 5000000,
  parameter int unsigned TIMEOUT_W      = 23
) (
  input  logic        clk50_dup,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_busy,
  output logic [15:0] int_address,
  output logic [7:0]  int_wr_data,
  output logic        int_write,
  output logic        int_read,
  output logic        int_req,
  input  logic        int_gnt,
  input  logic [7:0]  int_rd_data,
  output logic        overrun
);

  localparam logic [7:0]           CMD_WRITE     = 8'h57;
  localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);
`ifdef UART_PARSER_READ_EN
  localparam logic [7:0]           CMD_READ      = 8'h52;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_HI, S_ADDR_LO, S_LEN, S_WDATA, S_WBUS
`ifdef UART_PARSER_READ_EN
    , S_RBUS, S_RWAIT, S_TX
`endif
  } state_t;

  state_t               state, state_nxt;
  logic [15:0]          address_nxt;
  logic [7:0]           wr_data_nxt;
  logic [8:0]           remaining, remaining_nxt;
  logic [TIMEOUT_W-1:0] timeout_cnt, timeout_nxt;
  logic                 overrun_nxt;
  logic                 req_nxt;
  logic                 timed_out;
  logic                 last_byte;
`ifdef UART_PARSER_READ_EN
  logic                 is_read, is_read_nxt;
  logic [7:0]           tx_data_nxt;
  logic                 tx_valid_nxt;
`endif

  assign timed_out = !rx_valid && (timeout_cnt >= TIMEOUT_LIMIT);
  assign last_byte = (remaining == 9'd1);

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt     = state;
    address_nxt   = int_address;
    wr_data_nxt   = int_wr_data;
    remaining_nxt = remaining;
    overrun_nxt   = overrun;
    timeout_nxt   = rx_valid ? '0 :
                    (timeout_cnt >= TIMEOUT_LIMIT) ? timeout_cnt : timeout_cnt + TIMEOUT_W'(1);
`ifdef UART_PARSER_READ_EN
    is_read_nxt   = is_read;
    tx_data_nxt   = tx_data;
    tx_valid_nxt  = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (rx_valid && rx_data == CMD_WRITE) begin
          state_nxt = S_ADDR_HI;
`ifdef UART_PARSER_READ_EN
          is_read_nxt = 1'b0;
        end else if (rx_valid && rx_data == CMD_READ) begin
          state_nxt   = S_ADDR_HI;
          is_read_nxt = 1'b1;
`endif
        end
      end
      S_ADDR_HI: begin
        if (timed_out) state_nxt = S_IDLE;
        else if (rx_valid) begin
          address_nxt[15:8] = rx_data;
          state_nxt         = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (timed_out) state_nxt = S_IDLE;
        else if (rx_valid) begin
          address_nxt[7:0] = rx_data;
          state_nxt        = S_LEN;
        end
      end
      S_LEN: begin
        if (timed_out) state_nxt = S_IDLE;
        else if (rx_valid) begin
          // A length byte of zero encodes 256 transfers.
          remaining_nxt = {rx_data == 8'd0, rx_data};
          state_nxt     = S_WDATA;
`ifdef UART_PARSER_READ_EN
          if (is_read) state_nxt = S_RBUS;
`endif
        end
      end
      S_WDATA: begin
        if (timed_out) state_nxt = S_IDLE;
        else if (rx_valid) begin
          wr_data_nxt = rx_data;
          state_nxt   = S_WBUS;
        end
      end
      S_WBUS: begin
        if (rx_valid) overrun_nxt = 1'b1;
        if (int_gnt) begin
          address_nxt   = int_address + 16'd1;
          remaining_nxt = remaining - 9'd1;
          state_nxt     = last_byte ? S_IDLE : S_WDATA;
        end
      end
`ifdef UART_PARSER_READ_EN
      S_RBUS: begin
        if (rx_valid) overrun_nxt = 1'b1;
        if (int_gnt) state_nxt = S_RWAIT;
      end
      S_RWAIT: begin
        if (rx_valid) overrun_nxt = 1'b1;
        tx_data_nxt = int_rd_data;
        state_nxt   = S_TX;
      end
      S_TX: begin
        if (rx_valid) overrun_nxt = 1'b1;
        if (!tx_busy) begin
          tx_valid_nxt  = 1'b1;
          address_nxt   = int_address + 16'd1;
          remaining_nxt = remaining - 9'd1;
          state_nxt     = last_byte ? S_IDLE : S_RBUS;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase

    req_nxt = (state_nxt == S_WBUS);
`ifdef UART_PARSER_READ_EN
    req_nxt = req_nxt || (state_nxt == S_RBUS);
`endif
  end

  // NOTE: bus outputs are registered from the next state, so they only move on state changes.
  always_ff @(posedge clk50_dup or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      int_address <= '0;
      int_wr_data <= '0;
      remaining   <= '0;
      timeout_cnt <= '0;
      overrun     <= 1'b0;
      int_req     <= 1'b0;
      int_write   <= 1'b0;
    end else begin
      state       <= state_nxt;
      int_address <= address_nxt;
      int_wr_data <= wr_data_nxt;
      remaining   <= remaining_nxt;
      timeout_cnt <= timeout_nxt;
      overrun     <= overrun_nxt;
      int_req     <= req_nxt;
      int_write   <= (state_nxt == S_WBUS);
    end
  end

`ifdef UART_PARSER_READ_EN
  always_ff @(posedge clk50_dup or posedge rst) begin
    if (rst) begin
      is_read  <= 1'b0;
      int_read <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else begin
      is_read  <= is_read_nxt;
      int_read <= (state_nxt == S_RBUS);
      tx_data  <= tx_data_nxt;
      tx_valid <= tx_valid_nxt;
    end
  end
`else
  logic unused_read_inputs;
  assign unused_read_inputs = ^{tx_busy, int_rd_data};
  assign tx_data  = '0;
  assign tx_valid = 1'b0;
  assign int_read = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: randomized frames against a frame-level model,
// with a bus/memory model and UART transmitter model driven on the falling edge.
module tb_uart_cmd_parser;

  localparam int TO = 40;

  logic        clk50_dup = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic [15:0] int_address;
  logic [7:0]  int_wr_data;
  logic        int_write, int_read, int_req, int_gnt;
  logic [7:0]  int_rd_data;
  logic        overrun;

  uart_cmd_parser #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(6)) dut (
    .clk50_dup   (clk50_dup),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_busy     (tx_busy),
    .int_address (int_address),
    .int_wr_data (int_wr_data),
    .int_write   (int_write),
    .int_read    (int_read),
    .int_req     (int_req),
    .int_gnt     (int_gnt),
    .int_rd_data (int_rd_data),
    .overrun     (overrun)
  );

  always #10 clk50_dup = ~clk50_dup;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus bridge, memory and transmitter model
  logic [7:0]  bus_mem [65536];
  logic [7:0]  ref_mem [65536];
  int          gnt_mode  = 0;   // 0 always, 1 random, 2 never, 3 low one cycle after a write
  int          busy_mode = 0;   // 0 never busy, 1 random
  logic [23:0] wr_obs[$];
  logic [7:0]  tx_obs[$];
  logic [7:0]  dq[$];
  int          cyc = 0, lows = 0, busys = 0, req_seen = 0;
  int          req_rise_cyc = 0, tx_cyc = 0, wr_run = 0, last_wr_len = 0;
  logic        rd_pend = 1'b0, prev_req = 1'b0, prev_busy = 1'b0, wr_gnt_prev = 1'b0;
  logic [15:0] rd_addr = '0;

  always @(negedge clk50_dup) begin : bus_model
    logic g, b;
    cyc++;
    if (rst) begin
      int_gnt = 1'b0; rd_pend = 1'b0; prev_req = 1'b0;
      lows = 0; wr_gnt_prev = 1'b0; wr_run = 0;
    end else begin
      if (int_req && !prev_req) req_rise_cyc = cyc;
      prev_req = int_req;
      if (int_req) begin
        req_seen++;
        check("req_one_direction", 32'(int_write ^ int_read), 32'd1);
      end
      if (int_req && int_write) wr_run++;
      else if (wr_run != 0) begin last_wr_len = wr_run; wr_run = 0; end
      if (tx_valid) begin
        tx_obs.push_back(tx_data);
        tx_cyc = cyc;
        check("tx_valid_while_busy", 32'(prev_busy), 32'd0);
      end
      int_rd_data = rd_pend ? bus_mem[rd_addr] : 8'($urandom);
      case (gnt_mode)
        0:       g = 1'b1;
        2:       g = 1'b0;
        3:       g = !wr_gnt_prev;
        default: g = (lows >= 2) || ($urandom_range(0, 2) != 0);
      endcase
      lows    = g ? 0 : lows + 1;
      int_gnt = g;
      rd_pend = int_req && int_read && g;
      rd_addr = int_address;
      wr_gnt_prev = int_req && int_write && g;
      if (int_req && int_write && g) begin
        wr_obs.push_back({int_address, int_wr_data});
        bus_mem[int_address] = int_wr_data;
      end
      b = (busy_mode != 0) && (busys < 3) && ($urandom_range(0, 1) == 1);
      busys     = b ? busys + 1 : 0;
      tx_busy   = b;
      prev_busy = b;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk50_dup);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk50_dup);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic wait_until(input int nw, input int nt);
    int n = 0;
    while ((wr_obs.size() < nw || tx_obs.size() < nt) && n < 4000) begin
      @(negedge clk50_dup);
      n++;
    end
  endtask

  // Frame-level model: each delivered data byte k becomes one write at addr+k (mod 2^16).
  task automatic write_frame(input logic [15:0] addr, input logic [7:0] len,
                             input logic [7:0] data[$], input int nsend, input int gap);
    logic [7:0]  frame[$];
    logic [23:0] exp[$];
    logic [15:0] a;
    frame = {8'h57, addr[15:8], addr[7:0], len};
    foreach (data[i]) frame.push_back(data[i]);
    if (nsend < 0 || nsend > frame.size()) nsend = frame.size();
    wr_obs.delete();
    for (int k = 0; k < nsend; k++) begin
      send_byte(frame[k]);
      if (k >= 4) begin
        a = addr + 16'(k - 4);
        exp.push_back({a, frame[k]});
        ref_mem[a] = frame[k];
        wait_until(k - 3, 0);
      end
      repeat ((gap < 0) ? $urandom_range(0, 8) : gap) @(negedge clk50_dup);
    end
    if (nsend < frame.size()) repeat (TO + 5) @(negedge clk50_dup);
    else repeat (2) @(negedge clk50_dup);
    check("wr_count", wr_obs.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wr_obs.size(); i++)
      check("wr_addr_data", wr_obs[i], exp[i]);
  endtask

`ifdef UART_PARSER_READ_EN
  task automatic read_frame(input logic [15:0] addr, input logic [7:0] len);
    int n;
    n = (len == 8'd0) ? 256 : int'(len);
    tx_obs.delete();
    send_byte(8'h52); send_byte(addr[15:8]); send_byte(addr[7:0]); send_byte(len);
    wait_until(0, n);
    repeat (2) @(negedge clk50_dup);
    check("tx_count", tx_obs.size(), n);
    for (int i = 0; i < n && i < tx_obs.size(); i++)
      check("tx_byte", tx_obs[i], ref_mem[addr + 16'(i)]);
  endtask
`endif

  function automatic logic is_cmd(input logic [7:0] b);
`ifdef UART_PARSER_READ_EN
    return (b == 8'h57) || (b == 8'h52);
`else
    return (b == 8'h57);
`endif
  endfunction

  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  jb;
    logic [15:0] ra;
    int          n, ns;
    rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_busy = 1'b0; int_gnt = 1'b0; int_rd_data = '0;
    for (int i = 0; i < 65536; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    repeat (3) @(negedge clk50_dup);
    check("rst_int_req", int_req, 0);
    check("rst_int_write", int_write, 0);
    check("rst_int_read", int_read, 0);
    check("rst_int_address", int_address, 0);
    check("rst_int_wr_data", int_wr_data, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk50_dup);

    // Basic write against a bridge that drops grant for one cycle after each write
    gnt_mode = 3;
    dq = {8'hAA, 8'hBB};
    write_frame(16'h0010, 8'h02, dq, -1, -1);
    check("wbus_cycles", last_wr_len, 1);
    check("idle_after_write", int_req, 0);

    // Single read; disabled builds must ignore the whole frame
    gnt_mode = 0; busy_mode = 0;
    bus_mem[16'h0200] = 8'h5C; ref_mem[16'h0200] = 8'h5C;
`ifdef UART_PARSER_READ_EN
    read_frame(16'h0200, 8'h01);
    check("rd_latency", tx_cyc - req_rise_cyc, 3);
`else
    tx_obs.delete(); req_seen = 0;
    send_byte(8'h52); send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    repeat (20) @(negedge clk50_dup);
    check("r_ignored_req", req_seen, 0);
    check("r_ignored_tx", tx_obs.size(), 0);
`endif

    // Address wrap with LEN=0 (256 writes)
    gnt_mode = 1;
    dq.delete();
    for (int i = 0; i < 256; i++) dq.push_back(8'($urandom));
    write_frame(16'hFFFF, 8'h00, dq, -1, -1);
    check("wrap_second_addr", (wr_obs.size() > 1) ? 32'(wr_obs[1][23:8]) : 32'hDEAD, 32'h0000);

    // Timeout: abandoned header, then a complete frame
    dq = {8'h33};
    write_frame(16'h1234, 8'h01, dq, 2, -1);
    write_frame(16'h0000, 8'h01, dq, -1, -1);
    // Gaps just under the timeout must not abandon the frame
    gnt_mode = 0;
    dq = {8'h5A, 8'hA5};
    write_frame(16'h0300, 8'h02, dq, -1, TO - 6);

    // Randomized frames
    gnt_mode = 1; busy_mode = 1;
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        do jb = 8'($urandom); while (is_cmd(jb));
        send_byte(jb);
      end
      ra = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 6)) : 16'($urandom);
`ifdef UART_PARSER_READ_EN
      if ($urandom_range(0, 2) == 0) begin
        read_frame(ra, 8'($urandom_range(1, 16)));
        continue;
      end
`endif
      n = $urandom_range(1, 12);
      dq.delete();
      for (int i = 0; i < n; i++) dq.push_back(8'($urandom));
      ns = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3 + n) : -1;
      write_frame(ra, 8'(n), dq, ns, -1);
    end
    busy_mode = 0;
    check("no_overrun_yet", overrun, 0);

    // Overrun: byte arriving while a write waits for grant
    gnt_mode = 2;
    wr_obs.delete();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h40); send_byte(8'h01); send_byte(8'h77);
    repeat (3) @(negedge clk50_dup);
    check("wbus_held", {int_req, int_write, int_address, int_wr_data}, {1'b1, 1'b1, 16'h0040, 8'h77});
    send_byte(8'h57);
    check("overrun_set", overrun, 1);
    gnt_mode = 0;
    wait_until(1, 0);
    repeat (2) @(negedge clk50_dup);
    check("ovr_wr_count", wr_obs.size(), 1);
    check("ovr_wr", (wr_obs.size() > 0) ? 32'(wr_obs[0]) : 32'hDEAD, {8'h00, 16'h0040, 8'h77});
    ref_mem[16'h0040] = 8'h77;
    dq = {8'h55};
    write_frame(16'h0041, 8'h01, dq, -1, -1);
    check("overrun_sticky", overrun, 1);

    // Asynchronous reset in the middle of a write
    gnt_mode = 2;
    wr_obs.delete();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h50); send_byte(8'h01); send_byte(8'h99);
    repeat (2) @(negedge clk50_dup);
    check("pre_rst_req", int_req, 1);
    #3 rst = 1'b1;
    #1;
    check("rst_async_req", int_req, 0);
    check("rst_async_write", int_write, 0);
    check("rst_async_overrun", overrun, 0);
    check("rst_async_addr", int_address, 0);
    @(negedge clk50_dup);
    rst = 1'b0;
    gnt_mode = 1;
    repeat (3) @(negedge clk50_dup);
    check("no_write_after_rst", wr_obs.size(), 0);
    dq = {8'hA1, 8'hA2};
    write_frame(16'h0060, 8'h02, dq, -1, -1);
    check("final_tx_valid", tx_valid, 0);
    check("final_overrun", overrun, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
# uart_cmd_parser

Byte-level command parser between the UART receiver/transmitter and the internal register bus consumed by the UART-to-SRAM bridge. It decodes framed write/read commands from received bytes and issues one bus transaction per data byte with an auto-incrementing address. It honours the bridge's grant back-pressure and, for reads, returns bus data to the UART transmitter.

## Interface
- `TIMEOUT_CYCLES`, 5000000, idle cycles between received bytes before an incomplete command is abandoned (100 ms at 50 MHz).
- `TIMEOUT_W`, 23, width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.
- `clk50_dup  input  1  sole clock; all logic on its rising edge`
- `rst  input  1  asynchronous, active-high reset`
- `rx_data  input  8  received byte, valid when rx_valid=1`
- `rx_valid  input  1  single-cycle strobe per received byte`
- `tx_data  output  8  byte to transmit`
- `tx_valid  output  1  single-cycle strobe; issued only when tx_busy=0`
- `tx_busy  input  1  transmitter busy`
- `int_address  output  16  bus address`
- `int_wr_data  output  8  bus write data`
- `int_write  output  1  write control`
- `int_read  output  1  read control`
- `int_req  output  1  bus access request`
- `int_gnt  input  1  bus grant`
- `int_rd_data  input  8  read data, valid the cycle after a granted read`
- `overrun  output  1  sticky: a byte arrived while the parser could not accept it`

## Operation
- Frame: `CMD, ADDR_HI, ADDR_LO, LEN, [data × N]`. CMD 0x57 ('W') = write, 0x52 ('R') = read. LEN 1..255 = that many bytes; LEN 0 = 256. Write frames carry N data bytes; read frames carry none.
- States: IDLE, ADDR_HI, ADDR_LO, LEN, WDATA, WBUS, RBUS, RWAIT, TX.
- IDLE: on rx_valid with 'W'/'R', latch command and go to ADDR_HI. Any other byte is ignored silently.
- ADDR_HI/ADDR_LO: latch address bytes. LEN: load the 9-bit remaining counter (0→256). Then go to WDATA (write) or RBUS (read).
- WDATA: on rx_valid, latch the byte into int_wr_data and go to WBUS.
- WBUS: hold int_req=1, int_write=1, int_address and int_wr_data stable.
  - The transfer completes in the first cycle with int_gnt=1.
  - Next cycle: deassert req/write, increment the address, decrement remaining. Go to IDLE if remaining reaches 0, else WDATA.
- RBUS: hold int_req=1, int_read=1, int_address. On int_gnt=1, go to RWAIT (req/read deasserted).
- RWAIT: capture int_rd_data into tx_data and go to TX.
- TX: when tx_busy=0, pulse tx_valid for one cycle. Then increment address and decrement remaining. Go to IDLE if remaining reaches 0, else RBUS.
- Address arithmetic is 16-bit modulo: 0xFFFF+1 → 0x0000.
- rx_valid arriving in WBUS, RBUS, RWAIT or TX: the byte is dropped and overrun is set. Only rst clears overrun.
- Timeout: the counter clears on every rx_valid and increments otherwise, saturating. In ADDR_HI, ADDR_LO, LEN and WDATA, reaching TIMEOUT_CYCLES forces IDLE with no bus activity. The timeout does not apply in the bus or TX states.
- Reset (any time, including mid-frame or mid-transaction): state IDLE.
  - All outputs reset to 0, including int_address, int_wr_data, tx_data and overrun.
  - Remaining and timeout counters reset to 0.

## Timing
- The LEN byte (read) or a data byte (write) is accepted at edge T. int_req rises in the registered output at T+1.
- With grant high, a write occupies WBUS for exactly 1 cycle. Against a bridge with LATCH_DELAY=1, back-to-back writes are separated by UART byte time, so the bus is free again.
- Read latency with int_gnt=1 and tx_busy=0: RBUS (1) → RWAIT (1) → TX (1). tx_valid asserts 3 cycles after int_req first asserts.
- int_req is never asserted together with both int_write and int_read. Bus outputs change only on state transitions.

## Configuration
- `UART_PARSER_READ_EN` defined: 'R' frames are supported as described.
- `UART_PARSER_READ_EN` undefined:
  - 0x52 is treated as an unknown command byte.
  - RBUS, RWAIT and TX are not compiled in.
  - tx_data and tx_valid are tied to 0, and int_read is tied to 0.

## Test plan
- Write: feed bytes 57 00 10 02 AA BB, with a bridge model holding int_gnt low 1 cycle after each write → two single-cycle granted writes: (0x0010, 0xAA) then (0x0011, 0xBB); return to IDLE.
- Read: with memory model [0x0200]=0x5C, feed 52 02 00 01, tx_busy=0 → one tx_valid with tx_data=0x5C, exactly 3 cycles after int_req rises.
- Wrap and LEN=0: write frame at address 0xFFFF with LEN=00 and 256 data bytes → 256 writes; the second write goes to address 0x0000.
- Timeout: feed 57 12, then 5000000 idle cycles, then 57 00 00 01 33 → no write from the first frame; a single write (0x0000, 0x33).
- Overrun: inject rx_valid while in WBUS with int_gnt held low → byte dropped, overrun=1 until rst.
- Reset mid-frame: assert rst during WBUS → int_req and int_write drop to 0 asynchronously. A subsequent full frame executes normally.
